// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream handshake and instruction memory write port
interface imem_boot_loader_if #(parameter int ADDR_W = 8);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master(output in_data, in_valid, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave(input in_data, in_valid, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte stream to instruction memory loader with checksum gate on core_run
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic clk,
  input  logic rst,
  imem_boot_loader_if.slave bus,
  output logic core_run,
  output logic done,
  output logic error,
  output logic [ADDR_W:0] word_cnt
);
  typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
  state_t state;
  logic [7:0] sum;
  logic [7:0] len_lo;
  logic [1:0] lane;
  logic [23:0] word;
  logic [15:0] remain;
  logic hs;
  logic [15:0] n;
  assign hs = bus.in_valid && bus.in_ready;
  assign n = {bus.in_data, len_lo};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_LEN_LO;
      sum <= '0;
      len_lo <= '0;
      lane <= '0;
      word <= '0;
      remain <= '0;
      bus.in_ready <= 1'b1;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      core_run <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      word_cnt <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (hs) begin
        if (state != S_CSUM) sum <= sum + bus.in_data;
        case (state)
          S_LEN_LO: begin
            len_lo <= bus.in_data;
            state <= S_LEN_HI;
          end
          S_LEN_HI:
            if (n == 16'd0 || 32'(n) > MAX_WORDS) begin
              state <= S_ERR;
              error <= 1'b1;
              bus.in_ready <= 1'b0;
            end else begin
              remain <= n;
              state <= S_DATA;
            end
          S_DATA: begin
            // bytes enter at the top and shift down, so byte 0 ends in bits [7:0]
            lane <= lane + 2'd1;
            word <= {bus.in_data, word[23:8]};
            if (lane == 2'd3) begin
              bus.imem_we <= 1'b1;
              bus.imem_addr <= word_cnt[ADDR_W-1:0];
              bus.imem_wdata <= {bus.in_data, word};
              word_cnt <= word_cnt + 1'b1;
              remain <= remain - 16'd1;
              if (remain == 16'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == sum) begin
              state <= S_RUN;
              core_run <= 1'b1;
              done <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
endmodule
